// File: rtl/stage_if_pkg.sv
// stage_if_pkg: PC-select encodings, fetch FSM states, bubble word and alignment helper
package stage_if_pkg;
  typedef enum logic [1:0] {PCSRC_SEQ, PCSRC_BRANCH, PCSRC_JUMP, PCSRC_JREG} pcsrc_e;
  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HELD} if_state_e;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/stage_if_if_id_reg.sv
// if_id_reg: IF/ID register (clk, reset, hold, flush, pc_in/inst_in -> pc/inst); flush beats hold
module if_id_reg import stage_if_pkg::*; #(
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic [31:0] inst
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc   <= 32'h0;
      inst <= NOP_INST;
    end else if (flush) begin
      pc   <= 32'h0;
      inst <= NOP_INST;
    end else if (!hold) begin
      pc   <= pc_in;
      inst <= inst_in;
    end
endmodule

// File: rtl/stage_if.sv
// stage_if: fetch FSM + next-PC select + IF/ID (hazard/PCSrc/jump/branch in, imem req/ready port, PC/inst out)
module stage_if import stage_if_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] jmpAddress,
  input  logic [31:0] jmpReg,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] inst
);
  if_state_e   state, state_nx;
  logic [31:0] fetch_pc, fetch_nx, pend_pc, pend_nx, hold_buf, buf_nx, seq_pc, target;
  logic        jump, redir, ifid_hold, ifid_load, ifid_flush;
  assign seq_pc    = fetch_pc + 32'd4;
  assign jump      = !hazard && (PCSrc == PCSRC_JUMP || PCSrc == PCSRC_JREG);
  assign redir     = EX_BranchTaken || jump;
  assign target    = word_align(EX_BranchTaken ? EX_BranchAddr : PCSrc == PCSRC_JREG ? jmpReg : jmpAddress);
  assign imem_addr = fetch_pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= S_FETCH;
      fetch_pc <= word_align(RESET_PC);
      pend_pc  <= 32'h0;
      hold_buf <= NOP_INST;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_nx;
      pend_pc  <= pend_nx;
      hold_buf <= buf_nx;
    end
  always_comb begin
    state_nx = state == S_HELD  ? ((redir || !hazard) ? S_FETCH : S_HELD)
             : state == S_DRAIN ? (imem_ready ? S_FETCH : S_DRAIN)
             : imem_ready       ? ((hazard && !redir) ? S_HELD : S_FETCH)
             : (redir ? S_DRAIN : S_FETCH);
    fetch_nx = state == S_HELD  ? (redir ? target : hazard ? fetch_pc : seq_pc)
             : !imem_ready      ? fetch_pc
             : redir            ? target
             : state == S_DRAIN ? pend_pc
             : hazard           ? fetch_pc : seq_pc;
    pend_nx  = (state != S_HELD && !imem_ready && redir) ? target : pend_pc;
    buf_nx   = (state == S_FETCH && imem_ready && hazard && !redir) ? imem_rdata : hold_buf;
  end
  always_comb begin
    imem_req   = !reset && state != S_HELD;
    ifid_hold  = hazard && !EX_BranchTaken && state != S_DRAIN;
    ifid_load  = !redir && !hazard && (state == S_HELD || (state == S_FETCH && imem_ready));
    ifid_flush = !ifid_hold && !ifid_load;
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .hold   (ifid_hold),
    .flush  (ifid_flush),
    .pc_in  (seq_pc),
    .inst_in(state == S_HELD ? hold_buf : imem_rdata),
    .pc     (PC),
    .inst   (inst)
  );
endmodule
